mxu_pe_forward: RTL and testbench
=================================

Name: mxu_pe_forward

Overview:
Single processing element (PE) of the matrix-multiply unit (MXU) systolic array, forward/inference path.
- Performs one signed 8x8 multiply-accumulate into a 24-bit partial sum.
- Forwards activation, weight-load bus and phase to neighbouring PEs.
- Captures a weight from the load bus when it is addressed by row index.
- All outputs are registered: one pipeline stage per PE.

Parameters:
Y_INDEX, 8'd0, row index of this PE; weight load captures when load_weight_target_y equals this value.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
load_phase  input  1  1 = weight-load phase, 0 = compute phase
load_weight_target_y  input  8  row index addressed by the current load_weight
load_weight  input  8  weight value on the load bus
weight_mem  input  8  currently stored weight of this PE, signed two's complement; looped back from weight_mem_out by the array
activation  input  8  signed activation from the upstream PE
partial_sum  input  24  signed partial sum from the upstream PE
result  output  24  registered MAC result
phase_out  output  1  registered copy of load_phase
load_weight_target_y_out  output  8  registered copy of load_weight_target_y
activation_out  output  8  registered copy of activation
weight_out  output  8  registered copy of load_weight, forwarded down the load bus
weight_mem_out  output  8  registered next stored weight

Behaviour:
- Reset: on a rising clk edge with rst=1, all outputs are cleared to 0. Reset overrides every other input and takes effect in that cycle, including in the middle of a load or compute sequence.
- Latency: exactly 1 clk. Each output reflects the inputs sampled at the previous rising edge. There is no handshake, and a new input set is accepted every cycle.
- phase_out <= load_phase.
- load_weight_target_y_out <= load_weight_target_y, unconditionally.
- activation_out <= activation, unconditionally, in both phases.
- weight_out <= load_weight, unconditionally. The load bus always propagates, regardless of match.
- weight_mem_out:
  - If load_phase=1 and load_weight_target_y == Y_INDEX (full 8-bit compare), it takes load_weight.
  - Otherwise it takes weight_mem, holding the stored weight.
  - No capture occurs when load_phase=0, even if the index matches.
- result <= sext24(signed weight_mem * signed activation) + partial_sum.
  - The product is a 16-bit signed value, sign-extended to 24 bits.
  - The sum is truncated to 24 bits, i.e. two's-complement modulo 2^24, with no saturation and no overflow flag.
  - Example of wrap: 0x7FFFFF + 2500 gives 0x8009C3.
- result is computed in both phases using the weight_mem input, i.e. the pre-load weight. A weight captured in cycle N is used for MAC only once it is fed back as weight_mem.
- Datapath is purely combinational between the input pins and the output registers; there is no other internal state.

Test Plan:
- Reset and phase: assert rst for 1 cycle -> all outputs 0. Release rst, drive load_phase=0 -> phase_out=0 after 1 clk. Drive load_phase=1 -> phase_out=1 after 1 clk.
- Load hit (Y_INDEX=5): load_phase=1, target_y=5, load_weight=10, weight_mem=15 -> next cycle weight_mem_out=10, weight_out=10, load_weight_target_y_out=5, phase_out=1.
- Load miss and compute-phase hold:
  - load_phase=1, target_y=0, load_weight=10, weight_mem=88 -> weight_mem_out=88, weight_out=10, load_weight_target_y_out=0.
  - Repeat with load_phase=0, target_y=5 -> weight_mem_out=88.
- Unsigned-range MAC, activation_out checked = activation each case:
  - 10*5+20 -> 70
  - 0*15+30 -> 30
  - 25*0+40 -> 40
  - 127*127+100 -> 16229
- Signed MAC:
  - 0xF0*8+50 -> -78
  - 12*0xE0+100 -> -284
  - 0xF8*0xEC+50 -> 210
  - 0x80*127+0 -> -16256
- Accumulator extremes and reset priority:
  - 50*50+0x7FFFFF -> 24'd8391107 (0x8009C3)
  - 25*25+0x800000 -> -8387983
  - Assert rst in the same cycle as a non-zero MAC -> result=0 next cycle.

Source files
------------

// File: rtl/mxu_pe_forward.sv
`default_nettype none
// ============================================================================
// Module   : mxu_pe_forward
// Brief    : MXU systolic-array PE, forward path: signed 8x8 MAC into 24 bits,
//            forwards activation/load bus/phase, captures row-addressed weight.
// Revision : 1.0 - initial release
// ============================================================================
module mxu_pe_forward #(
  parameter logic [7:0] Y_INDEX = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_phase,
  input  logic [7:0]  load_weight_target_y,
  input  logic [7:0]  load_weight,
  input  logic [7:0]  weight_mem,
  input  logic [7:0]  activation,
  input  logic [23:0] partial_sum,
  output logic [23:0] result,
  output logic        phase_out,
  output logic [7:0]  load_weight_target_y_out,
  output logic [7:0]  activation_out,
  output logic [7:0]  weight_out,
  output logic [7:0]  weight_mem_out
);

  logic signed [15:0] w_product;
  logic        [23:0] w_sum;
  logic               w_capture;
  logic        [7:0]  w_next_weight;

  logic        [23:0] r_result;
  logic               r_phase;
  logic        [7:0]  r_target_y;
  logic        [7:0]  r_activation;
  logic        [7:0]  r_weight;
  logic        [7:0]  r_weight_mem;

  // MAC always uses the looped-back stored weight, never the one being loaded.
  assign w_product     = $signed(weight_mem) * $signed(activation);
  assign w_sum         = {{8{w_product[15]}}, w_product} + partial_sum;
  assign w_capture     = load_phase && (load_weight_target_y == Y_INDEX);
  assign w_next_weight = w_capture ? load_weight : weight_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result     <= 24'd0;
      r_phase      <= 1'b0;
      r_target_y   <= 8'd0;
      r_activation <= 8'd0;
      r_weight     <= 8'd0;
      r_weight_mem <= 8'd0;
    end else begin
      r_result     <= w_sum;
      r_phase      <= load_phase;
      r_target_y   <= load_weight_target_y;
      r_activation <= activation;
      r_weight     <= load_weight;
      r_weight_mem <= w_next_weight;
    end
  end

  assign result                   = r_result;
  assign phase_out                = r_phase;
  assign load_weight_target_y_out = r_target_y;
  assign activation_out           = r_activation;
  assign weight_out               = r_weight;
  assign weight_mem_out           = r_weight_mem;

endmodule
`default_nettype wire

// File: tb/tb_mxu_pe_forward.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxu_pe_forward
// Brief    : Directed self-checking bench for mxu_pe_forward (Y_INDEX = 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxu_pe_forward;

  logic        clk;
  logic        rst;
  logic        load_phase;
  logic [7:0]  load_weight_target_y;
  logic [7:0]  load_weight;
  logic [7:0]  weight_mem;
  logic [7:0]  activation;
  logic [23:0] partial_sum;
  logic [23:0] result;
  logic        phase_out;
  logic [7:0]  load_weight_target_y_out;
  logic [7:0]  activation_out;
  logic [7:0]  weight_out;
  logic [7:0]  weight_mem_out;

  int n_checks;
  int n_fail;

  mxu_pe_forward #(.Y_INDEX(8'd5)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .load_phase               (load_phase),
    .load_weight_target_y     (load_weight_target_y),
    .load_weight              (load_weight),
    .weight_mem               (weight_mem),
    .activation               (activation),
    .partial_sum              (partial_sum),
    .result                   (result),
    .phase_out                (phase_out),
    .load_weight_target_y_out (load_weight_target_y_out),
    .activation_out           (activation_out),
    .weight_out               (weight_out),
    .weight_mem_out           (weight_mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input set, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic r, input logic lp, input logic [7:0] ty,
                       input logic [7:0] lw, input logic [7:0] wm,
                       input logic [7:0] act, input logic [23:0] ps);
    rst = r; load_phase = lp; load_weight_target_y = ty;
    load_weight = lw; weight_mem = wm; activation = act; partial_sum = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(1'b0, 1'b1, 8'd7, 8'd9, 8'd3, 8'd4, 24'd11);
    apply(1'b1, 1'b1, 8'd7, 8'd9, 8'd3, 8'd4, 24'd11);
    n_checks++;
    if ({result, phase_out, load_weight_target_y_out, activation_out,
         weight_out, weight_mem_out} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got result=%h phase=%b ty=%h act=%h w=%h wm=%h, want all 0",
               result, phase_out, load_weight_target_y_out, activation_out,
               weight_out, weight_mem_out);
    end
  endtask

  task automatic test_phase;
    apply(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 24'd0);
    n_checks++;
    if (phase_out !== 1'b0) begin
      n_fail++; $display("FAIL phase_0: got %b want 0", phase_out);
    end
    apply(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 24'd0);
    n_checks++;
    if (phase_out !== 1'b1) begin
      n_fail++; $display("FAIL phase_1: got %b want 1", phase_out);
    end
  endtask

  task automatic test_load_hit;
    apply(1'b0, 1'b1, 8'd5, 8'd10, 8'd15, 8'd0, 24'd0);
    n_checks++;
    if ({weight_mem_out, weight_out, load_weight_target_y_out, phase_out} !==
        {8'd10, 8'd10, 8'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL load_hit: got wm=%0d w=%0d ty=%0d ph=%b want wm=10 w=10 ty=5 ph=1",
               weight_mem_out, weight_out, load_weight_target_y_out, phase_out);
    end
  endtask

  task automatic test_load_miss;
    apply(1'b0, 1'b1, 8'd0, 8'd10, 8'd88, 8'd0, 24'd0);
    n_checks++;
    if ({weight_mem_out, weight_out, load_weight_target_y_out} !==
        {8'd88, 8'd10, 8'd0}) begin
      n_fail++;
      $display("FAIL load_miss: got wm=%0d w=%0d ty=%0d want wm=88 w=10 ty=0",
               weight_mem_out, weight_out, load_weight_target_y_out);
    end
    apply(1'b0, 1'b0, 8'd5, 8'd10, 8'd88, 8'd0, 24'd0);
    n_checks++;
    if ({weight_mem_out, weight_out, phase_out} !== {8'd88, 8'd10, 1'b0}) begin
      n_fail++;
      $display("FAIL compute_hold: got wm=%0d w=%0d ph=%b want wm=88 w=10 ph=0",
               weight_mem_out, weight_out, phase_out);
    end
  endtask

  // Rows: weight_mem, activation, partial_sum, expected result.
  task automatic run_mac_table(input string tag, input logic [7:0] wm[4],
                               input logic [7:0] act[4], input logic [23:0] ps[4],
                               input logic [23:0] exp_r[4]);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 8'd0, 8'd0, wm[i], act[i], ps[i]);
      n_checks++;
      if (result !== exp_r[i] || activation_out !== act[i]) begin
        n_fail++;
        $display("FAIL %s[%0d]: got result=%h act_out=%h want result=%h act_out=%h",
                 tag, i, result, activation_out, exp_r[i], act[i]);
      end
    end
  endtask

  task automatic test_mac_unsigned;
    logic [7:0]  wm[4]  = '{8'd10, 8'd0, 8'd25, 8'd127};
    logic [7:0]  act[4] = '{8'd5, 8'd15, 8'd0, 8'd127};
    logic [23:0] ps[4]  = '{24'd20, 24'd30, 24'd40, 24'd100};
    logic [23:0] ex[4]  = '{24'd70, 24'd30, 24'd40, 24'd16229};
    run_mac_table("mac_unsigned", wm, act, ps, ex);
  endtask

  task automatic test_mac_signed;
    logic [7:0]  wm[4]  = '{8'hF0, 8'd12, 8'hF8, 8'h80};
    logic [7:0]  act[4] = '{8'd8, 8'hE0, 8'hEC, 8'd127};
    logic [23:0] ps[4]  = '{24'd50, 24'd100, 24'd50, 24'd0};
    logic [23:0] ex[4]  = '{24'hFFFFB2, 24'hFFFEE4, 24'd210, 24'hFFC080};
    run_mac_table("mac_signed", wm, act, ps, ex);
  endtask

  task automatic test_accum_extremes;
    apply(1'b0, 1'b0, 8'd0, 8'd0, 8'd50, 8'd50, 24'h7FFFFF);
    n_checks++;
    if (result !== 24'h8009C3) begin
      n_fail++; $display("FAIL wrap_pos: got %h want 8009c3", result);
    end
    apply(1'b0, 1'b0, 8'd0, 8'd0, 8'd25, 8'd25, 24'h800000);
    n_checks++;
    if (result !== 24'h800271) begin
      n_fail++; $display("FAIL min_acc: got %h want 800271", result);
    end
  endtask

  task automatic test_reset_priority;
    apply(1'b0, 1'b1, 8'd5, 8'd33, 8'd10, 8'd5, 24'd20);
    apply(1'b1, 1'b1, 8'd5, 8'd33, 8'd10, 8'd5, 24'd20);
    n_checks++;
    if (result !== 24'd0 || weight_mem_out !== 8'd0 || activation_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_priority: got result=%h wm=%h act=%h want 0",
               result, weight_mem_out, activation_out);
    end
    apply(1'b0, 1'b0, 8'd0, 8'd0, 8'd10, 8'd5, 24'd20);
    n_checks++;
    if (result !== 24'd70) begin
      n_fail++; $display("FAIL post_reset_mac: got %h want %h", result, 24'd70);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; load_phase = 1'b0; load_weight_target_y = 8'd0;
    load_weight = 8'd0; weight_mem = 8'd0; activation = 8'd0; partial_sum = 24'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_phase();
    test_load_hit();
    test_load_miss();
    test_mac_unsigned();
    test_mac_signed();
    test_accum_extremes();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
